// File: rtl/ysyx22041405_mem_arbiter.sv
// ysyx22041405_mem_arbiter
//   Shares the single core memory port between instruction fetch (IFU) and
//   load/store (LSU). One transaction is in flight at a time: it is accepted
//   in IDLE, presented to memory in REQ, and its response is routed back to
//   the owner in WAIT.
//
//   Optional feature macro: ARB_RR_EN
//     defined   - round-robin tie break (requester not granted last wins)
//     undefined - fixed priority, LSU wins ties
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   ifu_req_valid/ready, ifu_addr IFU request handshake and fetch address
//   ifu_rsp_valid, ifu_rdata      IFU response pulse and instruction
//   lsu_req_valid/ready           LSU request handshake
//   lsu_addr/we/wdata/mask        LSU request fields
//   lsu_rsp_valid, lsu_rdata      LSU response pulse and load data (0 on write)
//   mem_req_valid/ready           memory request handshake
//   mem_addr/wdata/we/mask        registered memory request fields
//   mem_rsp_valid, mem_rdata      memory response and read data
module ysyx22041405_mem_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             ifu_req_valid,
    output logic             ifu_req_ready,
    input  logic [WIDTH-1:0] ifu_addr,
    output logic             ifu_rsp_valid,
    output logic [WIDTH-1:0] ifu_rdata,

    input  logic             lsu_req_valid,
    output logic             lsu_req_ready,
    input  logic [WIDTH-1:0] lsu_addr,
    input  logic             lsu_we,
    input  logic [WIDTH-1:0] lsu_wdata,
    input  logic [7:0]       lsu_mask,
    output logic             lsu_rsp_valid,
    output logic [WIDTH-1:0] lsu_rdata,

    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_we,
    output logic [7:0]       mem_mask,
    input  logic             mem_rsp_valid,
    input  logic [WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             owner;      // 0 = IFU, 1 = LSU
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             req_we;
    logic [7:0]       req_mask;
    logic             tie_lsu;
    logic             grant_lsu;
    logic             accept;

`ifdef ARB_RR_EN
    logic             last;       // 0 = IFU, 1 = LSU granted most recently

    assign tie_lsu = ~last;
`else
    assign tie_lsu = 1'b1;
`endif

    // Winner among the current valids; only meaningful while in IDLE.
    assign grant_lsu = lsu_req_valid & (~ifu_req_valid | tie_lsu);

    assign mem_addr  = req_addr;
    assign mem_wdata = req_wdata;
    assign mem_we    = req_we;
    assign mem_mask  = req_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            owner     <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_we    <= 1'b0;
            req_mask  <= '0;
`ifdef ARB_RR_EN
            last      <= 1'b1;
`endif
        end else begin
            state <= state_next;
            if (accept) begin
                owner     <= lsu_req_ready;
                req_addr  <= lsu_req_ready ? lsu_addr : ifu_addr;
                req_wdata <= lsu_req_ready ? lsu_wdata : '0;
                req_we    <= lsu_req_ready & lsu_we;
                req_mask  <= lsu_req_ready ? lsu_mask : '0;
`ifdef ARB_RR_EN
                last      <= lsu_req_ready;
`endif
            end
        end
    end

    always_comb begin
        state_next    = state;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        accept        = 1'b0;
        mem_req_valid = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_rsp_valid = 1'b0;
        ifu_rdata     = '0;
        lsu_rdata     = '0;

        unique case (state)
            S_IDLE: begin
                // Readies are qualified by rst_n so they read 0 while reset
                // is held, even though the state register already sits in IDLE.
                ifu_req_ready = rst_n & ifu_req_valid & ~grant_lsu;
                lsu_req_ready = rst_n & grant_lsu;
                accept        = ifu_req_ready | lsu_req_ready;
                if (accept) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    if (owner) begin
                        lsu_rsp_valid = 1'b1;
                        lsu_rdata     = req_we ? '0 : mem_rdata;
                    end else begin
                        ifu_rsp_valid = 1'b1;
                        ifu_rdata     = mem_rdata;
                    end
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx22041405_mem_arbiter.sv
module tb_ysyx22041405_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_we;
    logic [31:0] lsu_wdata;
    logic [7:0]  lsu_mask;
    logic        lsu_rsp_valid;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_mask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    int n_cmp;
    int n_err;

    ysyx22041405_mem_arbiter #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_addr      (ifu_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rdata     (ifu_rdata),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_addr      (lsu_addr),
        .lsu_we        (lsu_we),
        .lsu_wdata     (lsu_wdata),
        .lsu_mask      (lsu_mask),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rdata     (lsu_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_mask      (mem_mask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are checked 1 time unit
    // later, well before the next rising edge.

    task automatic test_reset();
        rst_n         = 1'b0;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        ifu_addr      = 32'h1111_1111;
        lsu_addr      = 32'h2222_2222;
        lsu_we        = 1'b1;
        lsu_wdata     = 32'h3333_3333;
        lsu_mask      = 8'hFF;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h4444_4444;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_cmp++; if (ifu_req_ready !== 1'b0) begin n_err++; $display("FAIL reset_ifu_ready: got %0b want 0", ifu_req_ready); end
        n_cmp++; if (lsu_req_ready !== 1'b0) begin n_err++; $display("FAIL reset_lsu_ready: got %0b want 0", lsu_req_ready); end
        n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_mem_req_valid: got %0b want 0", mem_req_valid); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr: got %h want 00000000", mem_addr); end
        n_cmp++; if (mem_wdata !== 32'h0) begin n_err++; $display("FAIL reset_mem_wdata: got %h want 00000000", mem_wdata); end
        n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_we: got %0b want 0", mem_we); end
        n_cmp++; if (mem_mask !== 8'h0) begin n_err++; $display("FAIL reset_mem_mask: got %h want 00", mem_mask); end
        n_cmp++; if (ifu_rsp_valid !== 1'b0 || lsu_rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got ifu=%0b lsu=%0b want 0/0", ifu_rsp_valid, lsu_rsp_valid); end
        n_cmp++; if (ifu_rdata !== 32'h0 || lsu_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got ifu=%h lsu=%h want 0/0", ifu_rdata, lsu_rdata); end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        lsu_we        = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ifu_read();
        // Cycle N: request accepted
        @(negedge clk);
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0000;
        #1;
        n_cmp++; if (ifu_req_ready !== 1'b1) begin n_err++; $display("FAIL ifu_read_ready: got %0b want 1", ifu_req_ready); end
        n_cmp++; if (lsu_req_ready !== 1'b0) begin n_err++; $display("FAIL ifu_read_lsu_ready: got %0b want 0", lsu_req_ready); end
        // Cycle N+1: request on memory side
        @(negedge clk);
        ifu_req_valid = 1'b0;
        ifu_addr      = 32'hFFFF_FFFF;
        mem_req_ready = 1'b1;
        #1;
        n_cmp++; if (mem_req_valid !== 1'b1) begin n_err++; $display("FAIL ifu_read_mem_valid: got %0b want 1", mem_req_valid); end
        n_cmp++; if (mem_addr !== 32'h8000_0000) begin n_err++; $display("FAIL ifu_read_mem_addr: got %h want 80000000", mem_addr); end
        n_cmp++; if (mem_we !== 1'b0 || mem_mask !== 8'h00) begin n_err++; $display("FAIL ifu_read_mem_we_mask: got we=%0b mask=%h want 0/00", mem_we, mem_mask); end
        n_cmp++; if (ifu_req_ready !== 1'b0) begin n_err++; $display("FAIL ifu_read_busy_ready: got %0b want 0", ifu_req_ready); end
        // Cycle N+2: response
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h0000_0413;
        #1;
        n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL ifu_read_wait_mem_valid: got %0b want 0", mem_req_valid); end
        n_cmp++; if (ifu_rsp_valid !== 1'b1) begin n_err++; $display("FAIL ifu_read_rsp_valid: got %0b want 1", ifu_rsp_valid); end
        n_cmp++; if (ifu_rdata !== 32'h0000_0413) begin n_err++; $display("FAIL ifu_read_rdata: got %h want 00000413", ifu_rdata); end
        n_cmp++; if (lsu_rsp_valid !== 1'b0) begin n_err++; $display("FAIL ifu_read_lsu_rsp: got %0b want 0", lsu_rsp_valid); end
        // Cycle N+3: idle again, pulse gone
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        ifu_req_valid = 1'b1;
        #1;
        n_cmp++; if (ifu_rsp_valid !== 1'b0) begin n_err++; $display("FAIL ifu_read_pulse_len: got %0b want 0", ifu_rsp_valid); end
        n_cmp++; if (ifu_req_ready !== 1'b1) begin n_err++; $display("FAIL ifu_read_idle_n3: got ready=%0b want 1", ifu_req_ready); end
        ifu_req_valid = 1'b0;
    endtask

    task automatic test_lsu_write();
        @(negedge clk);
        lsu_req_valid = 1'b1;
        lsu_we        = 1'b1;
        lsu_addr      = 32'h8000_1000;
        lsu_wdata     = 32'hDEAD_BEEF;
        lsu_mask      = 8'h0F;
        #1;
        n_cmp++; if (lsu_req_ready !== 1'b1 || ifu_req_ready !== 1'b0) begin n_err++; $display("FAIL lsu_write_ready: got lsu=%0b ifu=%0b want 1/0", lsu_req_ready, ifu_req_ready); end
        @(negedge clk);
        lsu_req_valid = 1'b0;
        lsu_we        = 1'b0;
        lsu_addr      = 32'h0;
        lsu_wdata     = 32'h0;
        lsu_mask      = 8'h00;
        mem_req_ready = 1'b1;
        #1;
        n_cmp++; if (mem_req_valid !== 1'b1) begin n_err++; $display("FAIL lsu_write_mem_valid: got %0b want 1", mem_req_valid); end
        n_cmp++; if (mem_addr !== 32'h8000_1000) begin n_err++; $display("FAIL lsu_write_mem_addr: got %h want 80001000", mem_addr); end
        n_cmp++; if (mem_wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL lsu_write_mem_wdata: got %h want deadbeef", mem_wdata); end
        n_cmp++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL lsu_write_mem_we: got %0b want 1", mem_we); end
        n_cmp++; if (mem_mask !== 8'h0F) begin n_err++; $display("FAIL lsu_write_mem_mask: got %h want 0f", mem_mask); end
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h1234_5678;
        #1;
        n_cmp++; if (lsu_rsp_valid !== 1'b1) begin n_err++; $display("FAIL lsu_write_rsp_valid: got %0b want 1", lsu_rsp_valid); end
        n_cmp++; if (lsu_rdata !== 32'h0) begin n_err++; $display("FAIL lsu_write_rdata: got %h want 00000000", lsu_rdata); end
        n_cmp++; if (ifu_rsp_valid !== 1'b0) begin n_err++; $display("FAIL lsu_write_ifu_rsp: got %0b want 0", ifu_rsp_valid); end
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        #1;
        n_cmp++; if (lsu_rsp_valid !== 1'b0) begin n_err++; $display("FAIL lsu_write_pulse_len: got %0b want 0", lsu_rsp_valid); end
    endtask

    // Both requesters held valid across four back-to-back transactions.
    task automatic test_back_to_back();
        logic        exp_lsu;
        logic [31:0] rd;
        ifu_addr = 32'h8000_0200;
        lsu_addr = 32'h8000_3000;
        lsu_we   = 1'b0;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_RR_EN
            exp_lsu = (i % 2 == 1);
`else
            exp_lsu = 1'b1;
`endif
            rd = 32'h0000_1000 + i;
            @(negedge clk);
            ifu_req_valid = 1'b1;
            lsu_req_valid = 1'b1;
            #1;
            n_cmp++; if (ifu_req_ready !== ~exp_lsu || lsu_req_ready !== exp_lsu) begin n_err++; $display("FAIL b2b_grant[%0d]: got ifu=%0b lsu=%0b want %0b/%0b", i, ifu_req_ready, lsu_req_ready, ~exp_lsu, exp_lsu); end
            @(negedge clk);
            mem_req_ready = 1'b1;
            #1;
            n_cmp++; if (mem_addr !== (exp_lsu ? 32'h8000_3000 : 32'h8000_0200)) begin n_err++; $display("FAIL b2b_mem_addr[%0d]: got %h want %h", i, mem_addr, exp_lsu ? 32'h8000_3000 : 32'h8000_0200); end
            n_cmp++; if (ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_busy_ready[%0d]: got ifu=%0b lsu=%0b want 0/0", i, ifu_req_ready, lsu_req_ready); end
            @(negedge clk);
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b1;
            mem_rdata     = rd;
            #1;
            n_cmp++; if (ifu_rsp_valid !== ~exp_lsu || lsu_rsp_valid !== exp_lsu) begin n_err++; $display("FAIL b2b_rsp_route[%0d]: got ifu=%0b lsu=%0b want %0b/%0b", i, ifu_rsp_valid, lsu_rsp_valid, ~exp_lsu, exp_lsu); end
            n_cmp++; if ((exp_lsu ? lsu_rdata : ifu_rdata) !== rd) begin n_err++; $display("FAIL b2b_rdata[%0d]: got ifu=%h lsu=%h want %h on owner", i, ifu_rdata, lsu_rdata, rd); end
            n_cmp++; if (ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_wait_ready[%0d]: got ifu=%0b lsu=%0b want 0/0", i, ifu_req_ready, lsu_req_ready); end
            if (i == 3) begin
                ifu_req_valid = 1'b0;
                lsu_req_valid = 1'b0;
            end
        end
        @(negedge clk);
        mem_rsp_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        lsu_req_valid = 1'b1;
        lsu_we        = 1'b1;
        lsu_addr      = 32'h8000_2000;
        lsu_wdata     = 32'hCAFE_F00D;
        lsu_mask      = 8'hF0;
        #1;
        n_cmp++; if (lsu_req_ready !== 1'b1) begin n_err++; $display("FAIL bp_accept: got %0b want 1", lsu_req_ready); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            lsu_addr      = 32'h0BAD_0000 + c;
            lsu_wdata     = 32'h5555_0000 + c;
            lsu_mask      = 8'h01;
            lsu_we        = 1'b0;
            ifu_req_valid = 1'b1;
            mem_req_ready = 1'b0;
            #1;
            n_cmp++; if (mem_req_valid !== 1'b1) begin n_err++; $display("FAIL bp_mem_valid[%0d]: got %0b want 1", c, mem_req_valid); end
            n_cmp++; if (mem_addr !== 32'h8000_2000 || mem_wdata !== 32'hCAFE_F00D || mem_we !== 1'b1 || mem_mask !== 8'hF0) begin n_err++; $display("FAIL bp_fields[%0d]: got %h %h %0b %h want 80002000 cafef00d 1 f0", c, mem_addr, mem_wdata, mem_we, mem_mask); end
            n_cmp++; if (ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got ifu=%0b lsu=%0b want 0/0", c, ifu_req_ready, lsu_req_ready); end
            n_cmp++; if (ifu_rsp_valid !== 1'b0 || lsu_rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_rsp[%0d]: got ifu=%0b lsu=%0b want 0/0", c, ifu_rsp_valid, lsu_rsp_valid); end
        end
        @(negedge clk);
        mem_req_ready = 1'b1;
        lsu_req_valid = 1'b0;
        #1;
        n_cmp++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_2000) begin n_err++; $display("FAIL bp_release: got valid=%0b addr=%h want 1/80002000", mem_req_valid, mem_addr); end
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h7777_7777;
        ifu_req_valid = 1'b0;
        #1;
        n_cmp++; if (lsu_rsp_valid !== 1'b1 || lsu_rdata !== 32'h0) begin n_err++; $display("FAIL bp_complete: got valid=%0b rdata=%h want 1/00000000", lsu_rsp_valid, lsu_rdata); end
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        lsu_we        = 1'b0;
    endtask

    task automatic test_spurious();
        // Response while IDLE
        @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'hAAAA_AAAA;
        #1;
        n_cmp++; if (ifu_rsp_valid !== 1'b0 || lsu_rsp_valid !== 1'b0) begin n_err++; $display("FAIL spur_idle_rsp: got ifu=%0b lsu=%0b want 0/0", ifu_rsp_valid, lsu_rsp_valid); end
        n_cmp++; if (ifu_rdata !== 32'h0 || lsu_rdata !== 32'h0) begin n_err++; $display("FAIL spur_idle_rdata: got ifu=%h lsu=%h want 0/0", ifu_rdata, lsu_rdata); end
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0080;
        #1;
        n_cmp++; if (ifu_req_ready !== 1'b1) begin n_err++; $display("FAIL spur_idle_state: got ready=%0b want 1", ifu_req_ready); end
        // Response while REQ, memory not yet ready
        @(negedge clk);
        ifu_req_valid = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'hBBBB_BBBB;
        #1;
        n_cmp++; if (ifu_rsp_valid !== 1'b0 || lsu_rsp_valid !== 1'b0) begin n_err++; $display("FAIL spur_req_rsp: got ifu=%0b lsu=%0b want 0/0", ifu_rsp_valid, lsu_rsp_valid); end
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        #1;
        n_cmp++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0080) begin n_err++; $display("FAIL spur_req_state: got valid=%0b addr=%h want 1/80000080", mem_req_valid, mem_addr); end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h0000_0013;
        #1;
        n_cmp++; if (ifu_rsp_valid !== 1'b1 || ifu_rdata !== 32'h0000_0013) begin n_err++; $display("FAIL spur_complete: got valid=%0b rdata=%h want 1/00000013", ifu_rsp_valid, ifu_rdata); end
        @(negedge clk);
        mem_rsp_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0400;
        @(negedge clk);
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        // WAIT: response arrives, then reset asserts mid-cycle
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'hBAD0_BAD0;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        #1;
        n_cmp++; if (ifu_rsp_valid !== 1'b1 || mem_addr !== 32'h8000_0400) begin n_err++; $display("FAIL rst_mid_pre: got rsp=%0b addr=%h want 1/80000400", ifu_rsp_valid, mem_addr); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (ifu_rsp_valid !== 1'b0 || lsu_rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_rsp: got ifu=%0b lsu=%0b want 0/0", ifu_rsp_valid, lsu_rsp_valid); end
        n_cmp++; if (ifu_rdata !== 32'h0 || lsu_rdata !== 32'h0) begin n_err++; $display("FAIL rst_mid_rdata: got ifu=%h lsu=%h want 0/0", ifu_rdata, lsu_rdata); end
        n_cmp++; if (ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin n_err++; $display("FAIL rst_mid_ready: got ifu=%0b lsu=%0b want 0/0", ifu_req_ready, lsu_req_ready); end
        n_cmp++; if (mem_req_valid !== 1'b0 || mem_addr !== 32'h0 || mem_we !== 1'b0 || mem_mask !== 8'h0 || mem_wdata !== 32'h0) begin n_err++; $display("FAIL rst_mid_mem: got v=%0b a=%h we=%0b m=%h d=%h want all 0", mem_req_valid, mem_addr, mem_we, mem_mask, mem_wdata); end
        @(negedge clk);
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        rst_n         = 1'b1;
        #1;
        n_cmp++; if (ifu_rsp_valid !== 1'b0 || lsu_rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_late_rsp: got ifu=%0b lsu=%0b want 0/0", ifu_rsp_valid, lsu_rsp_valid); end
        @(negedge clk);
        #1;
        n_cmp++; if (ifu_rsp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_late_rsp2: got rsp=%0b mem_valid=%0b want 0/0", ifu_rsp_valid, mem_req_valid); end
        mem_rsp_valid = 1'b0;
        // Fresh IFU transaction after reset
        @(negedge clk);
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0100;
        #1;
        n_cmp++; if (ifu_req_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_new_ready: got %0b want 1", ifu_req_ready); end
        @(negedge clk);
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        n_cmp++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0100) begin n_err++; $display("FAIL rst_mid_new_req: got valid=%0b addr=%h want 1/80000100", mem_req_valid, mem_addr); end
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h0010_0073;
        #1;
        n_cmp++; if (ifu_rsp_valid !== 1'b1 || ifu_rdata !== 32'h0010_0073) begin n_err++; $display("FAIL rst_mid_new_rsp: got valid=%0b rdata=%h want 1/00100073", ifu_rsp_valid, ifu_rdata); end
        @(negedge clk);
        mem_rsp_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_ifu_read();
        test_lsu_write();
        test_back_to_back();
        test_backpressure();
        test_spurious();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
